// File: rtl/ysyx_23060240_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_lsu
//
// Load/store unit between the execute stage and a word-wide data-memory bus.
// It accepts one access at a time. It classifies the access as no-op,
// illegal, misaligned or bus access. It aligns store data into byte lanes
// with a write mask. It extracts and sign- or zero-extends load data, and
// aborts bus accesses that take TIMEOUT cycles or more.
//
// Parameters
//   TIMEOUT         cycles allowed in REQ+RESP before abort (>= 1)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake from execute (ready only in IDLE)
//   mem_rd_en/wr_en     load / store enables, sampled on accept
//   memory_rd_ctrl      1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw
//   memory_wr_ctrl      1 sb, 2 sh, 3 sw
//   addr, wdata         byte address, right-justified store data
//   out_valid/out_ready result handshake (valid only in DONE)
//   rdata, err          extended load data / failure flag
//   req_*               bus request channel (valid only in REQ)
//   resp_*              bus response channel (ready only in RESP)
//
// State table
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for in_valid; request fields latched on accept
//   REQ    | req_valid high, payload held until req_ready
//   RESP   | resp_ready high, waiting for resp_valid
//   DONE   | out_valid high, rdata/err held until out_ready
//
// Every output is either a register or a decode of the state register, so
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ysyx_23060240_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  memory_rd_ctrl,
  input  logic [7:0]  memory_wr_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wmask,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err
);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [2:0] RD_LB  = 3'd1;
  localparam logic [2:0] RD_LBU = 3'd2;
  localparam logic [2:0] RD_LH  = 3'd3;
  localparam logic [2:0] RD_LHU = 3'd4;
  localparam logic [2:0] RD_LW  = 3'd5;

  localparam logic [7:0] WR_SB  = 8'd1;
  localparam logic [7:0] WR_SH  = 8'd2;
  localparam logic [7:0] WR_SW  = 8'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          to_hit;

  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   req_addr_q;
  logic          req_wen_q;
  logic [31:0]   req_wdata_q;
  logic [3:0]    req_wmask_q;
  logic          is_load_q;
  logic [2:0]    rd_ctrl_q;
  logic [1:0]    off_q;

  logic          accept;

  // -------------------------------------------------------------------------
  // Request classification and store lane alignment (evaluated in IDLE only)
  // -------------------------------------------------------------------------
  logic [1:0]  in_off;
  logic        rd_legal, wr_legal;
  logic        acc_half, acc_word;
  logic        acc_illegal, acc_misal, acc_noop;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;

  always_comb begin
    in_off      = addr[1:0];
    rd_legal    = (memory_rd_ctrl >= RD_LB) && (memory_rd_ctrl <= RD_LW);
    wr_legal    = (memory_wr_ctrl >= WR_SB) && (memory_wr_ctrl <= WR_SW);
    acc_noop    = !mem_rd_en && !mem_wr_en;
    acc_illegal = (mem_rd_en && mem_wr_en)
                || (mem_rd_en && !rd_legal)
                || (mem_wr_en && !wr_legal);
    acc_half    = (mem_rd_en && ((memory_rd_ctrl == RD_LH) || (memory_rd_ctrl == RD_LHU)))
                || (mem_wr_en && (memory_wr_ctrl == WR_SH));
    acc_word    = (mem_rd_en && (memory_rd_ctrl == RD_LW))
                || (mem_wr_en && (memory_wr_ctrl == WR_SW));
    acc_misal   = (acc_half && in_off[0]) || (acc_word && (in_off != 2'b00));

    st_wdata    = wdata << {in_off, 3'b000};
    st_wmask    = 4'b0000;
    if (memory_wr_ctrl == WR_SB) begin
      st_wmask = 4'b0001 << in_off;
    end else if (memory_wr_ctrl == WR_SH) begin
      st_wmask = 4'b0011 << in_off;
    end else if (memory_wr_ctrl == WR_SW) begin
      st_wmask = 4'b1111;
    end
  end

  // -------------------------------------------------------------------------
  // Load data extraction from the bus word using the latched offset/code
  // -------------------------------------------------------------------------
  logic [31:0] ld_word;
  logic [31:0] ld_data;

  always_comb begin
    ld_word = resp_rdata >> {off_q, 3'b000};
    ld_data = ld_word;
    case (rd_ctrl_q)
      RD_LB:   ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      RD_LBU:  ld_data = {24'h000000, ld_word[7:0]};
      RD_LH:   ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      RD_LHU:  ld_data = {16'h0000, ld_word[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state, timeout counter, result capture
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    // The cycle in which the count would reach TIMEOUT is the last one;
    // the abort wins over a handshake seen in that same cycle.
    to_hit  = (cnt_inc == TO_VAL);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (acc_noop) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b0;
          end else if (acc_illegal || acc_misal) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        if (to_hit) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (req_ready) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        cnt_d = cnt_inc;
        if (to_hit) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (resp_valid) begin
          state_d = S_DONE;
          err_d   = resp_err;
          rdata_d = is_load_q ? ld_data : '0;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request payload, latched once on accept and held for the whole access
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      is_load_q   <= 1'b0;
      rd_ctrl_q   <= '0;
      off_q       <= '0;
    end else if (accept) begin
      req_addr_q  <= {addr[31:2], 2'b00};
      req_wen_q   <= mem_wr_en;
      req_wdata_q <= mem_wr_en ? st_wdata : '0;
      req_wmask_q <= mem_wr_en ? st_wmask : '0;
      is_load_q   <= mem_rd_en;
      rd_ctrl_q   <= memory_rd_ctrl;
      off_q       <= in_off;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready   = (state_q == S_IDLE);
  assign req_valid  = (state_q == S_REQ);
  assign resp_ready = (state_q == S_RESP);
  assign out_valid  = (state_q == S_DONE);

  assign rdata      = rdata_q;
  assign err        = err_q;
  assign req_addr   = req_addr_q;
  assign req_wen    = req_wen_q;
  assign req_wdata  = req_wdata_q;
  assign req_wmask  = req_wmask_q;

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
module tb_ysyx_23060240_lsu;

  localparam int TO = 6;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  memory_rd_ctrl;
  logic [7:0]  memory_wr_ctrl;
  logic [31:0] addr, wdata;
  logic        out_valid, out_ready;
  logic [31:0] rdata;
  logic        err;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic        rde;
    logic        wre;
    logic [2:0]  rc;
    logic [7:0]  wc;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rsp;
    logic        re;
  } acc_t;

  typedef struct packed {
    int          done_cyc;
    logic [31:0] rdata;
    logic        err;
    logic        saw_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wen;
    logic        stable;
  } obs_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        bus;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  ysyx_23060240_lsu #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .memory_rd_ctrl (memory_rd_ctrl),
    .memory_wr_ctrl (memory_wr_ctrl),
    .addr           (addr),
    .wdata          (wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .rdata          (rdata),
    .err            (err),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic acc_t mk(input logic rde, input logic wre, input logic [2:0] rc,
                              input logic [7:0] wc, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rsp, input logic re);
    acc_t x;
    x.rde = rde; x.wre = wre; x.rc = rc; x.wc = wc;
    x.a = a; x.wd = wd; x.rsp = rsp; x.re = re;
    return x;
  endfunction

  // Reference model: access size/alignment arithmetic, lane shift by byte
  // offset, truncation by modulo and sign extension by subtraction.
  // rw/sw are the bus wait cycles before req_ready / resp_valid.
  function automatic exp_t model(input acc_t x, input int rw, input int sw);
    exp_t        e;
    int          size;
    int          off;
    bit          sgn;
    logic [31:0] w;
    logic [31:0] lim;
    off     = int'(x.a % 32'd4);
    e.addr  = x.a - 32'(off);
    e.bus   = 1'b0;
    e.rdata = '0;
    e.err   = 1'b0;
    e.cyc   = 1;
    e.wdata = '0;
    e.mask  = '0;
    size    = 0;
    sgn     = 1'b0;
    if (!x.rde && !x.wre) return e;
    if (x.rde && x.wre) begin e.err = 1'b1; return e; end
    if (x.rde) begin
      case (x.rc)
        3'd1: begin size = 1; sgn = 1'b1; end
        3'd2: size = 1;
        3'd3: begin size = 2; sgn = 1'b1; end
        3'd4: size = 2;
        3'd5: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (x.wc)
        8'd1: size = 1;
        8'd2: size = 2;
        8'd3: size = 4;
        default: size = 0;
      endcase
    end
    if (size == 0 || (off % size) != 0) begin e.err = 1'b1; return e; end
    e.bus = 1'b1;
    if (x.wre) begin
      e.wdata = x.wd << (8 * off);
      e.mask  = 4'(((1 << size) - 1) << off);
    end
    if (rw + sw + 2 >= TO) begin
      e.cyc = 1 + TO;
      e.err = 1'b1;
      return e;
    end
    e.cyc = rw + sw + 3;
    e.err = x.re;
    if (x.rde) begin
      w = x.rsp >> (8 * off);
      if (size == 4) begin
        e.rdata = w;
      end else begin
        lim     = 32'd1 << (8 * size);
        e.rdata = w % lim;
        if (sgn && e.rdata >= (lim >> 1)) e.rdata = e.rdata - lim;
      end
    end
    return e;
  endfunction

  // Issues one access at a negedge and plays the bus side. Cycle 0 is the
  // accept cycle; done_cyc is the first cycle with out_valid high.
  task automatic run_access(input acc_t x, input int rw, input int sw, input bit stray,
                            output obs_t o);
    int nreq;
    int nresp;
    nreq  = 0;
    nresp = 0;
    o = '0;
    o.done_cyc = -1;
    o.stable   = 1'b1;
    in_valid = 1'b1;
    mem_rd_en = x.rde; mem_wr_en = x.wre;
    memory_rd_ctrl = x.rc; memory_wr_ctrl = x.wc;
    addr = x.a; wdata = x.wd;
    @(negedge clk);
    in_valid = 1'b0;
    mem_rd_en = 1'($urandom); mem_wr_en = 1'($urandom);
    memory_rd_ctrl = 3'($urandom); memory_wr_ctrl = 8'($urandom);
    addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = $urandom;
      resp_err   = 1'($urandom);
      if (out_valid === 1'b1) begin
        o.done_cyc = c;
        o.rdata    = rdata;
        o.err      = err;
        break;
      end
      if (req_valid === 1'b1) begin
        if (!o.saw_req) begin
          o.addr = req_addr; o.wdata = req_wdata; o.mask = req_wmask; o.wen = req_wen;
        end else if ({req_addr, req_wdata, req_wmask, req_wen} !== {o.addr, o.wdata, o.mask, o.wen}) begin
          o.stable = 1'b0;
        end
        o.saw_req = 1'b1;
        nreq++;
        req_ready  = (nreq == rw + 1);
        resp_valid = stray;
      end else if (resp_ready === 1'b1) begin
        nresp++;
        if (nresp == sw + 1) begin
          resp_valid = 1'b1;
          resp_rdata = x.rsp;
          resp_err   = x.re;
        end
      end
      @(negedge clk);
    end
    req_ready  = 1'b0;
    resp_valid = 1'b0;
  endtask

  // Holds out_ready low for w cycles, then completes the result handshake.
  task automatic drain(input int w, output bit held, output bit idle_after);
    logic [31:0] r0;
    logic        e0;
    r0   = rdata;
    e0   = err;
    held = 1'b1;
    for (int i = 0; i < w; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      if (out_valid !== 1'b1 || rdata !== r0 || err !== e0 || in_ready !== 1'b0) held = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    idle_after = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_total++;
    if ({out_valid, rdata, err, req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready} !== '0)
      $display("FAIL reset_outputs: got ov=%b rd=%h err=%b rv=%b ra=%h wen=%b wd=%h wm=%b rr=%b expected all 0",
               out_valid, rdata, err, req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    obs_t o;
    bit   h, id;
    run_access(mk(1'b1, 1'b0, 3'd5, 8'd0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0), 0, 0, 1'b0, o);
    n_total++;
    if (o.addr !== 32'h8000_0004 || o.mask !== 4'b0000 || o.wen !== 1'b0)
      $display("FAIL lw_req: got addr=%h mask=%b wen=%b expected 80000004/0000/0", o.addr, o.mask, o.wen);
    else n_pass++;
    n_total++;
    if (o.done_cyc !== 3) $display("FAIL lw_latency: got cycle %0d expected 3", o.done_cyc);
    else n_pass++;
    n_total++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0)
      $display("FAIL lw_data: got %h err=%b expected deadbeef err=0", o.rdata, o.err);
    else n_pass++;
    drain(0, h, id);
  endtask

  task automatic test_load_ext();
    acc_t        t[4];
    logic [31:0] exp_d[4];
    obs_t        o;
    bit          h, id;
    t[0] = mk(1'b1, 1'b0, 3'd1, 8'd0, 32'h8000_0003, 32'h0, 32'h8012_3456, 1'b0); exp_d[0] = 32'hFFFF_FF80;
    t[1] = mk(1'b1, 1'b0, 3'd2, 8'd0, 32'h8000_0003, 32'h0, 32'h8012_3456, 1'b0); exp_d[1] = 32'h0000_0080;
    t[2] = mk(1'b1, 1'b0, 3'd4, 8'd0, 32'h8000_0002, 32'h0, 32'h8012_3456, 1'b0); exp_d[2] = 32'h0000_8012;
    t[3] = mk(1'b1, 1'b0, 3'd3, 8'd0, 32'h8000_0000, 32'h0, 32'h1234_9ABC, 1'b0); exp_d[3] = 32'hFFFF_9ABC;
    for (int i = 0; i < 4; i++) begin
      run_access(t[i], 0, 0, 1'b0, o);
      n_total++;
      if (o.rdata !== exp_d[i] || o.err !== 1'b0 || o.done_cyc !== 3)
        $display("FAIL load_ext_%0d: got %h err=%b cyc=%0d expected %h err=0 cyc=3",
                 i, o.rdata, o.err, o.done_cyc, exp_d[i]);
      else n_pass++;
      drain(0, h, id);
    end
  endtask

  task automatic test_store();
    obs_t o;
    bit   h, id;
    run_access(mk(1'b0, 1'b1, 3'd0, 8'd2, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0), 3, 0, 1'b0, o);
    n_total++;
    if (o.addr !== 32'h8000_0000 || o.wdata !== 32'hBEEF_0000 || o.mask !== 4'b1100 || o.wen !== 1'b1)
      $display("FAIL sh_payload: got addr=%h wd=%h mask=%b wen=%b expected 80000000/beef0000/1100/1",
               o.addr, o.wdata, o.mask, o.wen);
    else n_pass++;
    n_total++;
    if (o.stable !== 1'b1) $display("FAIL sh_stable: got %b expected 1", o.stable);
    else n_pass++;
    n_total++;
    if (o.done_cyc !== 6 || o.err !== 1'b0 || o.rdata !== 32'h0)
      $display("FAIL sh_result: got cyc=%0d err=%b rd=%h expected 6/0/0", o.done_cyc, o.err, o.rdata);
    else n_pass++;
    drain(0, h, id);
    run_access(mk(1'b0, 1'b1, 3'd0, 8'd1, 32'h8000_0003, 32'h1234_56AB, 32'h0, 1'b1), 0, 0, 1'b0, o);
    n_total++;
    if (o.wdata !== 32'hAB00_0000 || o.mask !== 4'b1000 || o.err !== 1'b1)
      $display("FAIL sb_payload: got wd=%h mask=%b err=%b expected ab000000/1000/1", o.wdata, o.mask, o.err);
    else n_pass++;
    drain(0, h, id);
  endtask

  task automatic test_errors();
    acc_t t[9];
    logic exp_e[9];
    obs_t o;
    bit   h, id;
    t[0] = mk(1'b0, 1'b1, 3'd0, 8'd3,    32'h8000_0001, 32'h1, 32'h0, 1'b0); exp_e[0] = 1'b1;
    t[1] = mk(1'b1, 1'b1, 3'd5, 8'd3,    32'h8000_0000, 32'h1, 32'h0, 1'b0); exp_e[1] = 1'b1;
    t[2] = mk(1'b1, 1'b0, 3'd3, 8'd0,    32'h8000_0001, 32'h0, 32'h0, 1'b0); exp_e[2] = 1'b1;
    t[3] = mk(1'b1, 1'b0, 3'd5, 8'd0,    32'h8000_0002, 32'h0, 32'h0, 1'b0); exp_e[3] = 1'b1;
    t[4] = mk(1'b1, 1'b0, 3'd6, 8'd0,    32'h8000_0000, 32'h0, 32'h0, 1'b0); exp_e[4] = 1'b1;
    t[5] = mk(1'b1, 1'b0, 3'd0, 8'd0,    32'h8000_0000, 32'h0, 32'h0, 1'b0); exp_e[5] = 1'b1;
    t[6] = mk(1'b0, 1'b1, 3'd0, 8'h13,   32'h8000_0000, 32'h0, 32'h0, 1'b0); exp_e[6] = 1'b1;
    t[7] = mk(1'b0, 1'b0, 3'd5, 8'd3,    32'h8000_0003, 32'h0, 32'h0, 1'b0); exp_e[7] = 1'b0;
    t[8] = mk(1'b0, 1'b1, 3'd0, 8'd2,    32'h8000_0003, 32'h0, 32'h0, 1'b0); exp_e[8] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_access(t[i], 0, 0, 1'b0, o);
      n_total++;
      if (o.done_cyc !== 1 || o.err !== exp_e[i] || o.rdata !== 32'h0 || o.saw_req !== 1'b0)
        $display("FAIL early_done_%0d: got cyc=%0d err=%b rd=%h req=%b expected 1/%b/0/0",
                 i, o.done_cyc, o.err, o.rdata, o.saw_req, exp_e[i]);
      else n_pass++;
      drain(0, h, id);
    end
  endtask

  task automatic test_timeout();
    acc_t x;
    exp_t e;
    obs_t o;
    bit   h, id;
    int   rws[4];
    int   sws[4];
    x = mk(1'b1, 1'b0, 3'd5, 8'd0, 32'h8000_0010, 32'h0, 32'h5555_AAAA, 1'b0);
    run_access(x, 1000, 0, 1'b0, o);
    n_total++;
    if (o.done_cyc !== TO + 1 || o.err !== 1'b1 || o.rdata !== 32'h0)
      $display("FAIL timeout_req: got cyc=%0d err=%b rd=%h expected %0d/1/0", o.done_cyc, o.err, o.rdata, TO + 1);
    else n_pass++;
    drain(0, h, id);
    rws[0] = 0;      sws[0] = TO - 2;
    rws[1] = 0;      sws[1] = TO - 3;
    rws[2] = TO - 1; sws[2] = 0;
    rws[3] = TO - 2; sws[3] = 0;
    for (int i = 0; i < 4; i++) begin
      e = model(x, rws[i], sws[i]);
      run_access(x, rws[i], sws[i], 1'b0, o);
      n_total++;
      if (o.done_cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata)
        $display("FAIL timeout_edge_%0d: got cyc=%0d err=%b rd=%h expected %0d/%b/%h",
                 i, o.done_cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      else n_pass++;
      drain(0, h, id);
    end
  endtask

  task automatic test_stray_resp();
    obs_t o;
    bit   h, id;
    bit   ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D; resp_err = 1'b1;
      @(negedge clk);
      if (resp_ready !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    resp_valid = 1'b0;
    n_total++;
    if (!ok) $display("FAIL stray_idle: got rr=%b ov=%b ir=%b expected 0/0/1", resp_ready, out_valid, in_ready);
    else n_pass++;
    run_access(mk(1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 32'h0, 32'h0, 1'b0), 0, 0, 1'b0, o);
    n_total++;
    if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.done_cyc !== 1)
      $display("FAIL stray_noop: got rd=%h err=%b cyc=%0d expected 0/0/1", o.rdata, o.err, o.done_cyc);
    else n_pass++;
    drain(0, h, id);
  endtask

  task automatic test_backpressure();
    obs_t o;
    bit   h, id;
    run_access(mk(1'b1, 1'b0, 3'd5, 8'd0, 32'h8000_0008, 32'h0, 32'h1234_5678, 1'b1), 0, 0, 1'b0, o);
    n_total++;
    if (o.rdata !== 32'h1234_5678 || o.err !== 1'b1)
      $display("FAIL bp_data: got %h err=%b expected 12345678 err=1", o.rdata, o.err);
    else n_pass++;
    drain(5, h, id);
    n_total++;
    if (!h || !id) $display("FAIL bp_hold: got held=%b idle=%b expected 1/1", h, id);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    bit   h, id;
    run_access(mk(1'b1, 1'b0, 3'd2, 8'd0, 32'h8000_0001, 32'h0, 32'h0000_F100, 1'b0), 0, 0, 1'b0, o);
    drain(0, h, id);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", in_ready);
    else n_pass++;
    run_access(mk(1'b1, 1'b0, 3'd1, 8'd0, 32'h8000_0001, 32'h0, 32'h0000_F100, 1'b0), 0, 0, 1'b0, o);
    n_total++;
    if (o.rdata !== 32'hFFFF_FFF1 || o.done_cyc !== 3)
      $display("FAIL b2b_second: got %h cyc=%0d expected fffffff1 cyc=3", o.rdata, o.done_cyc);
    else n_pass++;
    drain(0, h, id);
  endtask

  task automatic test_random();
    acc_t x;
    exp_t e;
    obs_t o;
    bit   h, id;
    int   rw, sw, ow, kind;
    bit   stray;
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      x.rde = (kind >= 2 && kind <= 5) || kind == 1;
      x.wre = (kind >= 6) || kind == 1;
      x.rc  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom);
      x.wc  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      x.a   = 32'h8000_0000 + 32'($urandom_range(0, 63));
      x.wd  = $urandom;
      x.rsp = $urandom;
      x.re  = ($urandom_range(0, 7) == 0);
      rw    = int'($urandom_range(0, 3));
      sw    = int'($urandom_range(0, 3));
      ow    = int'($urandom_range(0, 2));
      stray = 1'($urandom);
      e = model(x, rw, sw);
      run_access(x, rw, sw, stray, o);
      n_total++;
      if (o.done_cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata)
        $display("FAIL rand_result_%0d: got cyc=%0d err=%b rd=%h expected %0d/%b/%h",
                 i, o.done_cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      else n_pass++;
      n_total++;
      if (o.saw_req !== e.bus) $display("FAIL rand_bus_%0d: got %b expected %b", i, o.saw_req, e.bus);
      else n_pass++;
      if (e.bus) begin
        n_total++;
        if (o.addr !== e.addr || o.mask !== e.mask || o.wen !== x.wre
            || (x.wre && o.wdata !== e.wdata) || o.stable !== 1'b1)
          $display("FAIL rand_req_%0d: got a=%h m=%b w=%b d=%h s=%b expected %h/%b/%b/%h/1",
                   i, o.addr, o.mask, o.wen, o.wdata, o.stable, e.addr, e.mask, x.wre, e.wdata);
        else n_pass++;
      end
      drain(ow, h, id);
      n_total++;
      if (!h || !id) $display("FAIL rand_drain_%0d: got held=%b idle=%b expected 1/1", i, h, id);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   h, id;
    in_valid = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0;
    memory_rd_ctrl = 3'd5; memory_wr_ctrl = 8'd0; addr = 32'h8000_0020; wdata = 32'h0;
    @(negedge clk);
    in_valid  = 1'b0;
    req_ready = 1'b1;
    for (int c = 0; c < 10 && resp_ready !== 1'b1; c++) @(negedge clk);
    req_ready = 1'b0;
    n_total++;
    if (resp_ready !== 1'b1) $display("FAIL rstmid_reach_resp: got %b expected 1", resp_ready);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1 ||
        {out_valid, rdata, err, req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready} !== '0)
      $display("FAIL rstmid_outputs: got ir=%b ov=%b rr=%b rv=%b ra=%h expected 1/0/0/0/0",
               in_ready, out_valid, resp_ready, req_valid, req_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_access(mk(1'b1, 1'b0, 3'd5, 8'd0, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 1'b0), 0, 0, 1'b0, o);
    n_total++;
    if (o.rdata !== 32'h0BAD_F00D || o.done_cyc !== 3)
      $display("FAIL rstmid_after: got %h cyc=%0d expected 0badf00d cyc=3", o.rdata, o.done_cyc);
    else n_pass++;
    drain(0, h, id);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    memory_rd_ctrl = '0; memory_wr_ctrl = '0; addr = '0; wdata = '0;
    out_ready = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_errors();
    test_timeout();
    test_stray_resp();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_23060240_lsu.md
# ysyx_23060240_lsu

Load/store unit that executes the memory access requested by the decoder's `mem_rd_en`/`mem_wr_en` and `memory_rd_ctrl`/`memory_wr_ctrl` codes. It sits between the execute stage, which provides the ALU address and rs2 data, and a word-wide data-memory bus with valid/ready handshakes. It aligns store data into byte lanes and generates the write mask. It extracts and sign- or zero-extends load data, and reports misaligned, illegal-code and timeout errors.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ+RESP before the access is aborted with an error.
- `clk`  in  1  clock; all registers update on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  an access request is present.
- `in_ready`  out  1  the unit can accept a request; high only in IDLE.
- `mem_rd_en`  in  1  load request, sampled on accept.
- `mem_wr_en`  in  1  store request, sampled on accept.
- `memory_rd_ctrl`  in  3  load code: 1 = lb, 2 = lbu, 3 = lh, 4 = lhu, 5 = lw.
- `memory_wr_ctrl`  in  8  store code: 1 = sb, 2 = sh, 3 = sw.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `out_valid`  out  1  the access result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `rdata`  out  32  extended load result; 0 for stores and no-ops.
- `err`  out  1  the access failed; qualified by `out_valid`.
- `req_valid`  out  1  bus request valid.
- `req_ready`  in  1  bus accepts the request.
- `req_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `req_wen`  out  1  1 = write.
- `req_wdata`  out  32  lane-aligned store data.
- `req_wmask`  out  4  byte-lane enables; 0 for reads.
- `resp_valid`  in  1  bus response valid.
- `resp_ready`  out  1  high only in RESP.
- `resp_rdata`  in  32  bus read word.
- `resp_err`  in  1  bus error.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. All outputs are registered or decoded from state only; no combinational path runs from input to output.
- IDLE, on `in_valid`:
  - Latch `addr`, `wdata`, both control codes and both enables. Clear the timeout counter.
  - Classify the access:
    - Neither enable set: no-op. Go to DONE with rdata = 0, err = 0.
    - Both enables set, rd code outside 1..5 with `mem_rd_en`, or wr code outside 1..3 with `mem_wr_en`: illegal. Go to DONE with err = 1.
    - Misaligned: halfword access with `addr[0]`=1, or word access with `addr[1:0]`≠0. Go to DONE with err = 1. No bus request is issued.
    - Otherwise: go to REQ.
- Store lane rules, with `off` = `addr[1:0]`:
  - `req_wdata` = `wdata << (8*off)`.
  - sb: `req_wmask` = `4'b0001 << off`.
  - sh: `req_wmask` = `4'b0011 << off`.
  - sw: `req_wmask` = `4'b1111`.
- REQ: hold `req_valid`=1 with stable payload. On `req_ready`, go to RESP.
- RESP: `resp_ready`=1. On `resp_valid`:
  - Capture `err` = `resp_err`.
  - For a load, compute `w = resp_rdata >> (8*off)`.
  - lb sign-extends `w[7:0]`; lbu zero-extends `w[7:0]`; lh sign-extends `w[15:0]`; lhu zero-extends `w[15:0]`; lw uses `w`.
  - Go to DONE.
- Timeout: the counter increments every cycle spent in REQ or RESP. When it reaches `TIMEOUT`, go to DONE with err = 1 and rdata = 0, and drop `req_valid`.
- `resp_valid` seen outside RESP (for example, a late response after a timeout) is ignored; `resp_ready` stays 0.
- DONE: `out_valid`=1, with `rdata`/`err` held stable. On `out_ready`, go to IDLE.

## Timing
- Reset values: state = IDLE, so `in_ready`=1. All other outputs are 0 (`out_valid`, `rdata`, `err`, `req_valid`, `req_addr`, `req_wen`, `req_wdata`, `req_wmask`, `resp_ready`). The timeout counter is 0.
- Latency with a zero-wait bus, where `req_ready` is high in the first REQ cycle and `resp_valid` is high in the first RESP cycle:
  - Accept in cycle 0.
  - `req_valid` in cycle 1.
  - `resp_ready` in cycle 2.
  - `out_valid` in cycle 3.
- No-op, illegal and misaligned accesses: `out_valid` in cycle 1.
- Throughput: at most one access in flight. A new accept is possible in the cycle after the `out_valid`&`out_ready` handshake.
- Backpressure: `out_valid`, `rdata` and `err` hold indefinitely while `out_ready`=0.
- `req_*` payload holds stable while `req_valid`=1 and `req_ready`=0.
- Reset mid-access in any state: return to IDLE immediately and drop `req_valid`/`out_valid`. The bus side must be reset by the same `rst`.
- Timeout boundary: with `TIMEOUT`=N, a response arriving in the N-th REQ+RESP cycle is lost to the timeout; DONE with err = 1 takes precedence.

## Test plan
- lw at 0x80000004 with bus returning 0xDEADBEEF -> `req_addr` 0x80000004, `req_wmask` 0; `out_valid` in cycle 3; rdata 0xDEADBEEF, err 0.
- lb at 0x80000003 with resp 0x80123456 -> rdata 0xFFFFFF80. lbu at the same address -> rdata 0x00000080. lhu at 0x80000002 -> rdata 0x00008012.
- sh at 0x80000002 with wdata 0x0000BEEF -> `req_addr` 0x80000000, `req_wdata` 0xBEEF0000, `req_wmask` 4'b1100, `req_wen` 1. `req_ready` held low 3 cycles -> payload stable throughout.
- sw at 0x80000001 -> `out_valid` in cycle 1, err 1, `req_valid` never asserted. Both enables set -> err 1.
- `TIMEOUT`=4 with `req_ready` tied 0 -> `out_valid` with err 1 after 4 REQ cycles. A later stray `resp_valid` in IDLE is ignored.
- `out_ready` low for 5 cycles in DONE -> `rdata`/`err` stable, `in_ready` 0. Assert `rst` while in RESP -> all outputs return to 0 asynchronously and `in_ready` goes to 1.
